// File: rtl/lc3b_control.sv
// Multi-cycle LC-3b control FSM: fetch, decode, execute, memory access, writeback.
// Latency (zero-wait memory): ALU/JMP/LEA/BR-not-taken 5, BR taken 6, LDR/STR 7 cycles.
// Backpressure: memory requests are held in FETCH2/LDR1/STR2 until mem_resp pulses.
module lc3b_control (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] opcode,
    input  logic       branch_enable,
    input  logic       imm5_enable,
    input  logic       imm11_enable,
    input  logic       mem_resp,
    output logic [1:0] pcmux_sel,
    output logic       load_pc,
    output logic       storemux_sel,
    output logic       load_ir,
    output logic       load_regfile,
    output logic       load_mar,
    output logic       load_mdr,
    output logic       load_cc,
    output logic [1:0] alumux_sel,
    output logic [1:0] regfilemux_sel,
    output logic       marmux_sel,
    output logic       mdrmux_sel,
    output logic [3:0] aluop,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] mem_byte_enable
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_AND  = 4'd1;
    localparam logic [3:0] ALU_NOT  = 4'd2;
    localparam logic [3:0] ALU_PASS = 4'd3;

    typedef enum logic [3:0] {
        ST_FETCH1, ST_FETCH2, ST_FETCH3, ST_DECODE,
        ST_ADD, ST_AND, ST_NOT, ST_BR, ST_BR_TAKEN,
        ST_CALC_ADDR, ST_LDR1, ST_LDR2, ST_STR1, ST_STR2,
        ST_JMP, ST_LEA
    } state_t;

    state_t state, next_state;

    // IR[11] only matters for JSR, which this controller does not sequence.
    logic unused_imm11;
    assign unused_imm11 = imm11_enable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_FETCH1;
        else          state <= next_state;
    end

    always_comb begin
        next_state      = state;
        pcmux_sel       = 2'd0;
        load_pc         = 1'b0;
        storemux_sel    = 1'b0;
        load_ir         = 1'b0;
        load_regfile    = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_cc         = 1'b0;
        alumux_sel      = 2'd0;
        regfilemux_sel  = 2'd0;
        marmux_sel      = 1'b0;
        mdrmux_sel      = 1'b0;
        aluop           = ALU_ADD;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b11;

        // Outputs are forced quiet while reset is held so an abandoned access never strobes.
        if (reset_n) begin
            case (state)
                ST_FETCH1: begin
                    marmux_sel = 1'b1;
                    load_mar   = 1'b1;
                    load_pc    = 1'b1;
                    next_state = ST_FETCH2;
                end
                ST_FETCH2: begin
                    mem_read   = 1'b1;
                    mdrmux_sel = 1'b1;
                    load_mdr   = 1'b1;
                    if (mem_resp) next_state = ST_FETCH3;
                end
                ST_FETCH3: begin
                    load_ir    = 1'b1;
                    next_state = ST_DECODE;
                end
                ST_DECODE: begin
                    case (opcode)
                        4'b0001:          next_state = ST_ADD;
                        4'b0101:          next_state = ST_AND;
                        4'b1001:          next_state = ST_NOT;
                        4'b0000:          next_state = ST_BR;
                        4'b0110, 4'b0111: next_state = ST_CALC_ADDR;
                        4'b1100:          next_state = ST_JMP;
                        4'b1110:          next_state = ST_LEA;
                        default:          next_state = ST_FETCH1;
                    endcase
                end
                ST_ADD, ST_AND: begin
                    aluop        = (state == ST_ADD) ? ALU_ADD : ALU_AND;
                    alumux_sel   = imm5_enable ? 2'd2 : 2'd0;
                    load_regfile = 1'b1;
                    load_cc      = 1'b1;
                    next_state   = ST_FETCH1;
                end
                ST_NOT: begin
                    aluop        = ALU_NOT;
                    load_regfile = 1'b1;
                    load_cc      = 1'b1;
                    next_state   = ST_FETCH1;
                end
                ST_BR: next_state = branch_enable ? ST_BR_TAKEN : ST_FETCH1;
                ST_BR_TAKEN: begin
                    pcmux_sel  = 2'd1;
                    load_pc    = 1'b1;
                    next_state = ST_FETCH1;
                end
                ST_CALC_ADDR: begin
                    alumux_sel = 2'd1;
                    load_mar   = 1'b1;
                    next_state = (opcode == 4'b0110) ? ST_LDR1 : ST_STR1;
                end
                ST_LDR1: begin
                    mem_read   = 1'b1;
                    mdrmux_sel = 1'b1;
                    load_mdr   = 1'b1;
                    if (mem_resp) next_state = ST_LDR2;
                end
                ST_LDR2: begin
                    regfilemux_sel = 2'd1;
                    load_regfile   = 1'b1;
                    load_cc        = 1'b1;
                    next_state     = ST_FETCH1;
                end
                ST_STR1: begin
                    storemux_sel = 1'b1;
                    aluop        = ALU_PASS;
                    load_mdr     = 1'b1;
                    next_state   = ST_STR2;
                end
                ST_STR2: begin
                    mem_write = 1'b1;
                    if (mem_resp) next_state = ST_FETCH1;
                end
                ST_JMP: begin
                    pcmux_sel  = 2'd2;
                    load_pc    = 1'b1;
                    next_state = ST_FETCH1;
                end
                ST_LEA: begin
                    regfilemux_sel = 2'd2;
                    load_regfile   = 1'b1;
                    load_cc        = 1'b1;
                    next_state     = ST_FETCH1;
                end
                default: next_state = ST_FETCH1;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3b_control.sv
// Randomized instruction stream against a per-instruction control-sequence model;
// expected per-cycle control vectors are queued by the driver and checked by a negedge monitor.
module tb_lc3b_control;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_AND  = 4'd1;
    localparam logic [3:0] ALU_NOT  = 4'd2;
    localparam logic [3:0] ALU_PASS = 4'd3;

    typedef struct packed {
        logic [1:0] pcmux_sel;
        logic       load_pc;
        logic       storemux_sel;
        logic       load_ir;
        logic       load_regfile;
        logic       load_mar;
        logic       load_mdr;
        logic       load_cc;
        logic [1:0] alumux_sel;
        logic [1:0] regfilemux_sel;
        logic       marmux_sel;
        logic       mdrmux_sel;
        logic [3:0] aluop;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_byte_enable;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       branch_enable = 1'b0;
    logic       imm5_enable = 1'b0;
    logic       imm11_enable = 1'b0;
    logic       mem_resp = 1'b0;
    logic [1:0] pcmux_sel, alumux_sel, regfilemux_sel, mem_byte_enable;
    logic       load_pc, storemux_sel, load_ir, load_regfile, load_mar, load_mdr, load_cc;
    logic       marmux_sel, mdrmux_sel, mem_read, mem_write;
    logic [3:0] aluop;

    int   vectors = 0;
    int   miscompares = 0;
    ctl_t exp_q[$];

    lc3b_control dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .branch_enable(branch_enable),
        .imm5_enable(imm5_enable), .imm11_enable(imm11_enable), .mem_resp(mem_resp),
        .pcmux_sel(pcmux_sel), .load_pc(load_pc), .storemux_sel(storemux_sel),
        .load_ir(load_ir), .load_regfile(load_regfile), .load_mar(load_mar),
        .load_mdr(load_mdr), .load_cc(load_cc), .alumux_sel(alumux_sel),
        .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel), .mdrmux_sel(mdrmux_sel),
        .aluop(aluop), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable)
    );

    always #5 clk = ~clk;

    // Monitor: one control vector per cycle, compared away from the rising edge.
    always @(negedge clk) begin
        ctl_t e, got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {pcmux_sel, load_pc, storemux_sel, load_ir, load_regfile, load_mar,
                   load_mdr, load_cc, alumux_sel, regfilemux_sel, marmux_sel, mdrmux_sel,
                   aluop, mem_read, mem_write, mem_byte_enable};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL ctl_vec #%0d t=%0t op=%b got=%h exp=%h", vectors, $time, opcode, got, e);
            end
        end
    end

    function automatic ctl_t dflt();
        ctl_t c = '0;
        c.aluop           = ALU_ADD;
        c.mem_byte_enable = 2'b11;
        return c;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    // One cycle: drive inputs, queue the expected outputs, advance past the next edge.
    task automatic step(input ctl_t e, input logic resp, input logic br);
        mem_resp      = resp;
        branch_enable = br;
        imm11_enable  = rbit();
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch1();
        ctl_t c = dflt();
        c.marmux_sel = 1'b1; c.load_mar = 1'b1; c.load_pc = 1'b1;
        step(c, rbit(), rbit());
    endtask

    function automatic ctl_t mem_rd();
        ctl_t c = dflt();
        c.mem_read = 1'b1; c.mdrmux_sel = 1'b1; c.load_mdr = 1'b1;
        return c;
    endfunction

    function automatic ctl_t wb(input logic [1:0] rsel);
        ctl_t c = dflt();
        c.regfilemux_sel = rsel; c.load_regfile = 1'b1; c.load_cc = 1'b1;
        return c;
    endfunction

    // Reference model: the full control sequence of one instruction from the ISA rules.
    task automatic run_instr(input logic [3:0] op, input logic imm5, input logic br,
                             input int wf, input int wm, input logic stray);
        ctl_t c;
        opcode      = op;
        imm5_enable = imm5;
        fetch1();
        for (int i = 0; i <= wf; i++) step(mem_rd(), i == wf, rbit());
        c = dflt(); c.load_ir = 1'b1;
        step(c, rbit(), rbit());
        step(dflt(), stray, rbit());
        case (op)
            4'b0001, 4'b0101: begin
                c = wb(2'd0);
                c.aluop      = (op == 4'b0001) ? ALU_ADD : ALU_AND;
                c.alumux_sel = imm5 ? 2'd2 : 2'd0;
                step(c, rbit(), rbit());
            end
            4'b1001: begin
                c = wb(2'd0); c.aluop = ALU_NOT;
                step(c, rbit(), rbit());
            end
            4'b0000: begin
                step(dflt(), rbit(), br);
                if (br) begin
                    c = dflt(); c.pcmux_sel = 2'd1; c.load_pc = 1'b1;
                    step(c, rbit(), rbit());
                end
            end
            4'b0110, 4'b0111: begin
                c = dflt(); c.alumux_sel = 2'd1; c.load_mar = 1'b1;
                step(c, rbit(), rbit());
                if (op == 4'b0110) begin
                    for (int i = 0; i <= wm; i++) step(mem_rd(), i == wm, rbit());
                    step(wb(2'd1), rbit(), rbit());
                end else begin
                    c = dflt(); c.storemux_sel = 1'b1; c.aluop = ALU_PASS; c.load_mdr = 1'b1;
                    step(c, rbit(), rbit());
                    for (int i = 0; i <= wm; i++) begin
                        c = dflt(); c.mem_write = 1'b1;
                        step(c, i == wm, rbit());
                    end
                end
            end
            4'b1100: begin
                c = dflt(); c.pcmux_sel = 2'd2; c.load_pc = 1'b1;
                step(c, rbit(), rbit());
            end
            4'b1110: step(wb(2'd2), rbit(), rbit());
            default: ;
        endcase
    endtask

    initial begin
        logic [3:0] ops [9];
        logic [3:0] op;
        ops = '{4'b0001, 4'b0101, 4'b1001, 4'b0000, 4'b0110, 4'b0111, 4'b1100, 4'b1110, 4'b1111};

        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(dflt(), rbit(), rbit());
        reset_n = 1'b1;

        // Reset during a fetch wait: request must vanish immediately and no load fires.
        opcode = 4'b0001;
        fetch1();
        step(mem_rd(), 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        vectors++;
        if (mem_read !== 1'b0 || load_mdr !== 1'b0 || load_mar !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_fetch2 got mem_read=%b load_mdr=%b load_mar=%b exp 0 0 0",
                     mem_read, load_mdr, load_mar);
        end
        step(dflt(), 1'b1, 1'b0);
        step(dflt(), 1'b0, 1'b0);
        reset_n = 1'b1;

        // Directed cases, then a random instruction stream.
        run_instr(4'b0001, 1'b1, 1'b0, 3, 0, 1'b0);
        run_instr(4'b0000, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(4'b0000, 1'b0, 1'b1, 0, 0, 1'b0);
        run_instr(4'b0110, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(4'b0111, 1'b0, 1'b0, 0, 2, 1'b0);
        run_instr(4'b1111, 1'b0, 1'b0, 0, 0, 1'b1);
        run_instr(4'b0101, 1'b0, 1'b0, 1, 0, 1'b0);
        for (int n = 0; n < 80; n++) begin
            op = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 0)) : ops[$urandom_range(8, 0)];
            run_instr(op, rbit(), rbit(), $urandom_range(3, 0), $urandom_range(3, 0), rbit());
        end

        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain got %0d pending exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lc3b_control.md
Name: lc3b_control

Overview:
- Multi-cycle control FSM that sequences the LC-3b datapath: fetch, decode, execute, memory access and writeback.
- Drives every datapath control input and the memory read/write strobes.
- Consumes opcode and status flags from the datapath plus the memory response.
- Sits beside the datapath inside the CPU top level.

Parameters:
- none (encodings fixed by lc3b_types)

Ports:
- clk  in  1  system clock, all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  4  lc3b_opcode from IR
- branch_enable  in  1  nzp compare result from datapath
- imm5_enable  in  1  IR[5] immediate select
- imm11_enable  in  1  IR[11]; unused by the supported opcodes
- mem_resp  in  1  memory completion, single-cycle pulse
- pcmux_sel  out  2  0=pc+2, 1=br_add, 2=sr1_out
- load_pc  out  1  PC load enable
- storemux_sel  out  1  0=sr1 field, 1=dest field as regfile src_a
- load_ir  out  1  IR load enable
- load_regfile  out  1  register file write enable
- load_mar  out  1  MAR load enable
- load_mdr  out  1  MDR load enable
- load_cc  out  1  CC load enable
- alumux_sel  out  2  0=sr2_out, 1=adj6, 2=sext imm5
- regfilemux_sel  out  2  0=alu, 1=mdr, 2=br_add
- marmux_sel  out  1  0=alu_out, 1=pc
- mdrmux_sel  out  1  0=alu_out, 1=mem_rdata
- aluop  out  lc3b_aluop  ALU operation
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_byte_enable  out  2  always 2'b11

Behaviour:
- Moore FSM. Every control output defaults to 0 (aluop=alu_add, mem_byte_enable=2'b11) in every state unless listed below.
- Reset (reset_n=0, asynchronous): state=FETCH1 and all outputs at their defaults. Reset during a memory wait abandons the access; no load strobe fires.
- FETCH1: marmux_sel=1, load_mar=1, pcmux_sel=0, load_pc=1. Next state FETCH2.
- FETCH2: mem_read=1, mdrmux_sel=1, load_mdr=1.
  - Stays in FETCH2 while mem_resp=0.
  - Goes to FETCH3 on mem_resp=1.
  - mem_read is held continuously until the response arrives.
- FETCH3: load_ir=1. Next state DECODE.
- DECODE: no strobes. Next state by opcode:
  - 0001 goes to ADD
  - 0101 goes to AND
  - 1001 goes to NOT
  - 0000 goes to BR
  - 0110 and 0111 go to CALC_ADDR
  - 1100 goes to JMP
  - 1110 goes to LEA
  - any other opcode goes to FETCH1 (treated as a NOP)
- ADD / AND: aluop=alu_add or alu_and; alumux_sel=2 if imm5_enable else 0; regfilemux_sel=0; load_regfile=1; load_cc=1. Next state FETCH1.
- NOT: aluop=alu_not, load_regfile=1, load_cc=1. Next state FETCH1.
- BR: no strobes. Next state BR_TAKEN if branch_enable=1, else FETCH1.
- BR_TAKEN: pcmux_sel=1, load_pc=1. Next state FETCH1.
- CALC_ADDR: alumux_sel=1, aluop=alu_add, marmux_sel=0, load_mar=1. Next state LDR1 (opcode 0110) or STR1 (opcode 0111).
- LDR1: mem_read=1, mdrmux_sel=1, load_mdr=1. Waits on mem_resp, then goes to LDR2.
- LDR2: regfilemux_sel=1, load_regfile=1, load_cc=1. Next state FETCH1.
- STR1: storemux_sel=1, aluop=alu_pass, mdrmux_sel=0, load_mdr=1. Next state STR2.
- STR2: mem_write=1. Waits on mem_resp, then goes to FETCH1.
- JMP: pcmux_sel=2, load_pc=1. Next state FETCH1.
- LEA: regfilemux_sel=2, load_regfile=1, load_cc=1. Next state FETCH1.
- mem_read and mem_write are never asserted in the same cycle.
- A mem_resp outside FETCH2, LDR1 or STR2 is ignored.
- Latency with zero-wait memory (mem_resp in the first request cycle):
  - ALU ops: 5 cycles
  - BR not taken: 5 cycles; BR taken: 6 cycles
  - JMP, LEA: 5 cycles
  - LDR: 7 cycles
  - STR: 7 cycles

Test Plan:
- Reset asserted in FETCH2 while mem_read=1 -> mem_read drops the same cycle; after release, the first cycle is FETCH1 with load_mar=1, marmux_sel=1.
- Fetch ADD (opcode 0001, imm5_enable=1), mem_resp delayed 3 cycles -> mem_read high 4 cycles; load_ir a cycle later; then one cycle with alumux_sel=2, load_regfile=1, load_cc=1.
- BR with branch_enable=0 then =1 -> first: no load_pc after the fetch increment; second: BR_TAKEN with pcmux_sel=1, load_pc=1.
- LDR (0110), zero-wait memory -> CALC_ADDR alumux_sel=1, load_mar=1; LDR1 mem_read=1, mdrmux_sel=1; LDR2 regfilemux_sel=1, load_regfile=1; 7 cycles total.
- STR (0111) -> STR1 storemux_sel=1, aluop=alu_pass, load_mdr=1; STR2 mem_write=1 held until mem_resp; mem_read=0 throughout.
- Opcode 1111 and a stray mem_resp in DECODE -> return to FETCH1, no load_regfile, load_pc, load_cc or memory strobe.
